// File: rtl/nibble_diff_scanner.sv
// Sequential group-by-group comparator: scans two W-bit operands one G-bit group
// per clock, MSB group first. Optional early termination via `EARLY_EXIT_EN.
module nibble_diff_scanner #(
    parameter int W  = 16,
    parameter int G  = 4,
    parameter int CW = $clog2(W / G + 1),
    parameter int IW = $clog2(W / G)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    output logic          busy,
    output logic          done,
    output logic [W/G-1:0] eq_mask,
    output logic [CW-1:0] diff_cnt,
    output logic          any_diff,
    output logic [IW-1:0] first_diff
);

    localparam int N = W / G;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [N-1:0]   eq_mask_q, eq_mask_d;
    logic [CW-1:0]  diff_cnt_q, diff_cnt_d;
    logic           any_diff_q, any_diff_d;
    logic [IW-1:0]  first_diff_q, first_diff_d;

    logic [G-1:0]   ga_s, gb_s;
    logic           grp_eq_s;
    logic           accept_s;
    logic           stop_s;

    assign accept_s = start & ((state_q == IDLE) | (state_q == DONE));

    // Shared group comparator: select group idx from the latched operands.
    always_comb begin
        ga_s = '0;
        gb_s = '0;
        for (int g = 0; g < N; g++) begin
            ga_s = (idx_q == IW'(g)) ? a_q[g*G +: G] : ga_s;
            gb_s = (idx_q == IW'(g)) ? b_q[g*G +: G] : gb_s;
        end
    end

    assign grp_eq_s = (ga_s == gb_s);

`ifdef EARLY_EXIT_EN
    assign stop_s = (idx_q == IW'(0)) | ~grp_eq_s;
`else
    assign stop_s = (idx_q == IW'(0));
`endif

    // State and all output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            idx_q        <= IW'(N - 1);
            eq_mask_q    <= '0;
            diff_cnt_q   <= '0;
            any_diff_q   <= 1'b0;
            first_diff_q <= '0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            a_q          <= a_d;
            b_q          <= b_d;
            idx_q        <= idx_d;
            eq_mask_q    <= eq_mask_d;
            diff_cnt_q   <= diff_cnt_d;
            any_diff_q   <= any_diff_d;
            first_diff_q <= first_diff_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = start ? SCAN : IDLE;
            SCAN:    state_d = stop_s ? DONE : SCAN;
            DONE:    state_d = start ? SCAN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs, precomputed from the next state so they leave a flop.
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            SCAN:    busy_d = 1'b1;
            DONE:    done_d = 1'b1;
            default: begin
                busy_d = 1'b0;
                done_d = 1'b0;
            end
        endcase
    end

    // Operand capture and per-group result accumulation.
    always_comb begin
        a_d          = a_q;
        b_d          = b_q;
        idx_d        = idx_q;
        eq_mask_d    = eq_mask_q;
        diff_cnt_d   = diff_cnt_q;
        any_diff_d   = any_diff_q;
        first_diff_d = first_diff_q;
        if (accept_s) begin
            a_d          = a;
            b_d          = b;
            idx_d        = IW'(N - 1);
            eq_mask_d    = '0;
            diff_cnt_d   = '0;
            any_diff_d   = 1'b0;
            first_diff_d = '0;
        end else if (state_q == SCAN) begin
            eq_mask_d[idx_q] = grp_eq_s;
            diff_cnt_d       = grp_eq_s ? diff_cnt_q : diff_cnt_q + CW'(1);
            any_diff_d       = any_diff_q | ~grp_eq_s;
            first_diff_d     = (any_diff_q | grp_eq_s) ? first_diff_q : idx_q;
            idx_d            = stop_s ? idx_q : idx_q - IW'(1);
        end else begin
            idx_d = idx_q;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign eq_mask    = eq_mask_q;
    assign diff_cnt   = diff_cnt_q;
    assign any_diff   = any_diff_q;
    assign first_diff = first_diff_q;

endmodule
